lsu_port: RTL

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_port.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu_port.sv
// lsu_port -- single-port load/store unit between a core and a word-wide
// data memory.
//
// Takes one byte/half/word request at a time, turns it into one word beat,
// or two when misaligned support is enabled, with byte-lane enables.
// Returns load data sign- or zero-extended.
//
// Optional feature: define LSU_MISALIGN_EN to split accesses that cross a
// word boundary into two beats. Without it, any misaligned access completes
// immediately with rsp_err and never touches memory.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        core request handshake (ready only when idle)
//   req_we, req_size           store flag, funct3 size (b/h/w/bu/hu)
//   req_addr, req_wdata        byte address, right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err one-cycle completion pulse, load data, error
//   mem_req/mem_gnt            word request held until granted
//   mem_we/mem_be/mem_addr/mem_wdata  beat attributes (registered, stable)
//   mem_rvalid/mem_rdata       one return per grant, data for loads
module lsu_port #(
   parameter int unsigned N = 12
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   input  logic        mem_gnt,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_EN
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

   state_t         state_q, state_d;
   logic           req_ready_q, req_ready_d;
   logic           we_q, we_d;
   logic [2:0]     size_q, size_d;
   logic [1:0]     off_q, off_d;
   logic [N-3:0]   word_q, word_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_err_q, rsp_err_d;
   logic [31:0]    rsp_rdata_q, rsp_rdata_d;
   logic           mem_req_q, mem_req_d;
   logic           mem_we_q, mem_we_d;
   logic [3:0]     mem_be_q, mem_be_d;
   logic [31:0]    mem_addr_q, mem_addr_d;
   logic [31:0]    mem_wdata_q, mem_wdata_d;
`ifdef LSU_MISALIGN_EN
   logic [3:0]     be1_q, be1_d;
   logic [31:0]    wdata1_q, wdata1_d;
   logic [31:0]    rdata0_q, rdata0_d;
   logic [N-3:0]   word_next;
   logic [63:0]    load_split;
`else
   logic           req_misal;
`endif

   logic           req_bad_size;
   logic           req_err;
   logic [7:0]     req_lanes;
   logic [63:0]    req_sh;
   logic [31:0]    load_one;
   logic           unused_bits;

   // Lane mask of the whole access across two adjacent words: low nibble is
   // beat 0, high nibble is what spills into the next word.
   function automatic logic [7:0] lanes_f(input logic [2:0] size, input logic [1:0] off);
      logic [7:0] m;
      case (size[1:0])
         2'b00:   m = 8'h01;
         2'b01:   m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   function automatic logic [31:0] word_addr(input logic [N-3:0] w);
      logic [31:0] a;
      a = '0;
      a[N-1:2] = w;
      return a;
   endfunction

   // size[2] selects zero extension (bu/hu)
   function automatic logic [31:0] ext_f(input logic [2:0] size, input logic [31:0] d);
      logic [31:0] r;
      case (size[1:0])
         2'b00:   r = {{24{d[7] & ~size[2]}}, d[7:0]};
         2'b01:   r = {{16{d[15] & ~size[2]}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign req_bad_size = (req_size[1:0] == 2'b11) || (req_size == 3'b110);
   assign req_lanes    = lanes_f(req_size, req_addr[1:0]);
   assign req_sh       = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
   assign load_one     = mem_rdata >> {off_q, 3'b000};

`ifdef LSU_MISALIGN_EN
   assign req_err     = req_bad_size;
   assign word_next   = word_q + {{(N-3){1'b0}}, 1'b1};
   assign load_split  = {mem_rdata, rdata0_q} >> {off_q, 3'b000};
   assign unused_bits = ^{req_addr[31:N], load_split[63:32]};
`else
   assign req_misal   = (req_size[1:0] == 2'b01) ? req_addr[0] :
                        (req_size[1:0] == 2'b10) ? (req_addr[1:0] != 2'b00) : 1'b0;
   assign req_err     = req_bad_size || req_misal;
   assign unused_bits = ^{req_addr[31:N], req_lanes[7:4], req_sh[63:32]};
`endif

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      size_d      = size_q;
      off_d       = off_q;
      word_d      = word_q;
`ifdef LSU_MISALIGN_EN
      be1_d       = be1_q;
      wdata1_d    = wdata1_q;
      rdata0_d    = rdata0_q;
`endif
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_be_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               we_d   = req_we;
               size_d = req_size;
               off_d  = req_addr[1:0];
               word_d = req_addr[N-1:2];
`ifdef LSU_MISALIGN_EN
               be1_d    = req_lanes[7:4];
               wdata1_d = req_sh[63:32];
`endif
               if (req_err) begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  state_d     = REQ0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_we;
                  mem_be_d    = req_lanes[3:0];
                  mem_addr_d  = word_addr(req_addr[N-1:2]);
                  mem_wdata_d = req_sh[31:0];
               end
            end
         end
`ifdef LSU_MISALIGN_EN
         REQ0, REQ1: begin
`else
         REQ0: begin
`endif
            if (mem_gnt) begin
`ifdef LSU_MISALIGN_EN
               state_d = (state_q == REQ0) ? WAIT0 : WAIT1;
`else
               state_d = WAIT0;
`endif
            end else begin
               mem_req_d   = 1'b1;
               mem_we_d    = mem_we_q;
               mem_be_d    = mem_be_q;
               mem_addr_d  = mem_addr_q;
               mem_wdata_d = mem_wdata_q;
            end
         end
         WAIT0: begin
            if (mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
               // Spilled lanes mean a second beat to the next word (wraps).
               if (|be1_q) begin
                  state_d     = REQ1;
                  rdata0_d    = mem_rdata;
                  mem_req_d   = 1'b1;
                  mem_we_d    = we_q;
                  mem_be_d    = be1_q;
                  mem_addr_d  = word_addr(word_next);
                  mem_wdata_d = wdata1_q;
               end else begin
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_rdata_d = we_q ? '0 : ext_f(size_q, load_one);
               end
`else
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? '0 : ext_f(size_q, load_one);
`endif
            end
         end
`ifdef LSU_MISALIGN_EN
         WAIT1: begin
            if (mem_rvalid) begin
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? '0 : ext_f(size_q, load_split[31:0]);
            end
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Registered so that it stays low through reset and rises one edge later.
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_ready_q <= 1'b0;
         we_q        <= 1'b0;
         size_q      <= '0;
         off_q       <= '0;
         word_q      <= '0;
`ifdef LSU_MISALIGN_EN
         be1_q       <= '0;
         wdata1_q    <= '0;
         rdata0_q    <= '0;
`endif
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         we_q        <= we_d;
         size_q      <= size_d;
         off_q       <= off_d;
         word_q      <= word_d;
`ifdef LSU_MISALIGN_EN
         be1_q       <= be1_d;
         wdata1_q    <= wdata1_d;
         rdata0_q    <= rdata0_d;
`endif
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
